// File: rtl/mem_to_axil_if.sv
// AXI-Lite bus bundle shared by initiators and targets.
// Master modport: drives AW/W/AR channels and B/R readies.
// Slave modport : drives AW/W/AR readies and B/R channels.
interface AXI_LITE #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/mem_to_axil.sv
// mem_to_axil: bridges a single-port memory request interface onto an
// AXI-Lite master port, one transaction in flight at a time.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/we/addr/strb/wdata  memory request (captured on gnt)
//   gnt               combinational accept, only in IDLE and out of reset
//   rvalid/rdata/err  one-cycle registered completion (reads and writes)
//   master            AXI-Lite initiator port
// Build option: define MEM_TO_AXIL_ERR_EN to report resp[1] on err and
// zero rdata on a failed read; otherwise err is 0 and rdata forwards r_data.
module mem_to_axil #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [STRB_WIDTH-1:0] strb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  gnt,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  AXI_LITE.Master               master
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [STRB_WIDTH-1:0] strb;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state_q, state_d;
  req_t                  cur_q, cur_d;
  logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  b_ready_q, b_ready_d, ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  b_err, r_err;
  logic [DATA_WIDTH-1:0] r_fwd;
  logic                  unused_resp;

  assign aw_hs = aw_valid_q && master.aw_ready;
  assign w_hs  = w_valid_q  && master.w_ready;
  assign b_hs  = b_ready_q  && master.b_valid;
  assign ar_hs = ar_valid_q && master.ar_ready;
  assign r_hs  = r_ready_q  && master.r_valid;

  // Response error policy
`ifdef MEM_TO_AXIL_ERR_EN
  assign b_err = master.b_resp[1];
  assign r_err = master.r_resp[1];
  assign r_fwd = r_err ? '0 : master.r_data;
`else
  assign b_err = 1'b0;
  assign r_err = 1'b0;
  assign r_fwd = master.r_data;
`endif
  assign unused_resp = ^{master.b_resp, master.r_resp};

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    gnt        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && !rst) begin
          gnt         = 1'b1;
          cur_d.addr  = addr;
          cur_d.strb  = strb;
          cur_d.wdata = wdata;
          // The captured direction lives in the state choice
          if (we) begin
            state_d    = WRITE;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = READ;
            ar_valid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        // Same-cycle handshakes count as done immediately
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WRESP;
          b_ready_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          b_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          err_d     = b_err;
        end
      end
      READ: begin
        if (ar_hs) begin
          state_d    = RRESP;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RRESP: begin
        if (r_hs) begin
          state_d   = IDLE;
          r_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_fwd;
          err_d     = r_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  assign master.aw_addr  = cur_q.addr;
  assign master.aw_prot  = PROT;
  assign master.aw_valid = aw_valid_q;
  assign master.w_data   = cur_q.wdata;
  assign master.w_strb   = cur_q.strb;
  assign master.w_valid  = w_valid_q;
  assign master.b_ready  = b_ready_q;
  assign master.ar_addr  = cur_q.addr;
  assign master.ar_prot  = PROT;
  assign master.ar_valid = ar_valid_q;
  assign master.r_ready  = r_ready_q;

endmodule

// File: tb/tb_mem_to_axil.sv
// Bench for mem_to_axil: stall-configurable AXI-Lite RAM slave, a
// transaction-level scoreboard, a vector table, hand-written corner
// sequences and a randomized phase.
module tb_mem_to_axil;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [31:0] GARBAGE   = 32'hBAD0_BAD0;
  localparam logic [31:0] MAP_BYTES = 32'h0000_0040;
`ifdef MEM_TO_AXIL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, req, we;
  logic [AW-1:0] addr;
  logic [SW-1:0] strb;
  logic [DW-1:0] wdata;
  logic          gnt, rvalid, err;
  logic [DW-1:0] rdata;

  AXI_LITE #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ax ();

  mem_to_axil #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT(3'b000)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .strb(strb),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .master(ax)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AXI-Lite RAM slave (16 words at 0x00..0x3F) ----------------
  int aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic          aw_got, w_got;
  logic [AW-1:0] awa_q;
  logic [DW-1:0] wd_q, rd_q;
  logic [SW-1:0] ws_q;
  logic [1:0]    br_q, rr_q;
  logic [DW-1:0] smem [16] = '{default: '0};
  logic          aw_hs, w_hs, ar_hs, wr_fire;
  logic [AW-1:0] cur_awa;
  logic [DW-1:0] cur_wd;
  logic [SW-1:0] cur_ws;

  assign ax.aw_ready = (aw_cnt >= aw_stall);
  assign ax.w_ready  = (w_cnt >= w_stall);
  assign ax.ar_ready = (ar_cnt >= ar_stall);
  assign ax.b_valid  = (b_wait == 0);
  assign ax.b_resp   = br_q;
  assign ax.r_valid  = (r_wait == 0);
  assign ax.r_data   = rd_q;
  assign ax.r_resp   = rr_q;

  assign aw_hs   = ax.aw_valid && ax.aw_ready;
  assign w_hs    = ax.w_valid && ax.w_ready;
  assign ar_hs   = ax.ar_valid && ax.ar_ready;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs);
  assign cur_awa = aw_got ? awa_q : ax.aw_addr;
  assign cur_wd  = w_got ? wd_q : ax.w_data;
  assign cur_ws  = w_got ? ws_q : ax.w_strb;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      b_wait <= -1; r_wait <= -1;
      aw_got <= 1'b0; w_got <= 1'b0;
      br_q <= 2'b00; rr_q <= 2'b00; rd_q <= '0;
    end else begin
      aw_cnt <= (ax.aw_valid && !ax.aw_ready) ? aw_cnt + 1 : 0;
      w_cnt  <= (ax.w_valid && !ax.w_ready) ? w_cnt + 1 : 0;
      ar_cnt <= (ax.ar_valid && !ax.ar_ready) ? ar_cnt + 1 : 0;
      if (aw_hs && !wr_fire) begin
        aw_got <= 1'b1;
        awa_q  <= ax.aw_addr;
      end
      if (w_hs && !wr_fire) begin
        w_got <= 1'b1;
        wd_q  <= ax.w_data;
        ws_q  <= ax.w_strb;
      end
      if (wr_fire) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_wait <= b_stall;
        if (cur_awa < MAP_BYTES) begin
          br_q <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (cur_ws[b]) smem[cur_awa[5:2]][8*b +: 8] <= cur_wd[8*b +: 8];
        end else begin
          br_q <= 2'b11;
        end
      end else if (ax.b_valid && ax.b_ready) begin
        b_wait <= -1;
      end else if (b_wait > 0) begin
        b_wait <= b_wait - 1;
      end
      if (ar_hs) begin
        r_wait <= r_stall;
        rd_q   <= (ax.ar_addr < MAP_BYTES) ? smem[ax.ar_addr[5:2]] : GARBAGE;
        rr_q   <= (ax.ar_addr < MAP_BYTES) ? 2'b00 : 2'b11;
      end else if (ax.r_valid && ax.r_ready) begin
        r_wait <= -1;
      end else if (r_wait > 0) begin
        r_wait <= r_wait - 1;
      end
    end
  end

  // ---------------- Scoreboard: transaction-level memory model ----------------
  typedef struct {
    int          lat;
    int          t0;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [16] = '{default: '0};
  int          exp_lat_next = -1;

  // Samples one time unit before each rising edge
  initial begin
    exp_t        e;
    logic        mapped;
    logic        p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;
    p_rst = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        sbq.delete();
      end else begin
        if (rvalid) begin
          chk("rvalid_pending", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rdata", rdata, e.rd);
            chk("err", 32'(err), 32'(e.er));
            if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          end
        end
        if (gnt) begin
          chk("outstanding", 32'(sbq.size()), 32'd0);
          mapped = (addr < MAP_BYTES);
          e.lat  = exp_lat_next;
          e.t0   = cyc;
          e.er   = ERR_EN && !mapped;
          if (we) begin
            if (mapped)
              for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
            e.rd = 32'd0;
          end else begin
            e.rd = mapped ? ref_mem[addr[5:2]] : (ERR_EN ? 32'd0 : GARBAGE);
          end
          sbq.push_back(e);
        end
        if (!p_rst && p_awv === 1'b1 && p_awr === 1'b0) begin
          chk("aw_valid_stable", 32'(ax.aw_valid), 32'd1);
          chk("aw_addr_stable", ax.aw_addr, p_awa);
        end
        if (!p_rst && p_wv === 1'b1 && p_wr === 1'b0) begin
          chk("w_valid_stable", 32'(ax.w_valid), 32'd1);
          chk("w_data_stable", ax.w_data, p_wd);
          chk("w_strb_stable", 32'(ax.w_strb), 32'(p_ws));
        end
        if (!p_rst && p_arv === 1'b1 && p_arr === 1'b0) begin
          chk("ar_valid_stable", 32'(ax.ar_valid), 32'd1);
          chk("ar_addr_stable", ax.ar_addr, p_ara);
        end
        if (ax.b_ready)
          chk("b_ready_alone", 32'({ax.aw_valid, ax.w_valid, ax.ar_valid, ax.r_ready}), 32'd0);
        if (ax.r_ready)
          chk("r_ready_alone", 32'({ax.aw_valid, ax.w_valid, ax.ar_valid, ax.b_ready}), 32'd0);
      end
      p_rst = rst;
      p_awv = ax.aw_valid; p_awr = ax.aw_ready; p_awa = ax.aw_addr;
      p_wv  = ax.w_valid;  p_wr  = ax.w_ready;  p_wd  = ax.w_data; p_ws = ax.w_strb;
      p_arv = ax.ar_valid; p_arr = ax.ar_ready; p_ara = ax.ar_addr;
    end
  end

  // ---------------- Driver ----------------
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    bit got;
    bit done;
    int t0;
    got = 1'b0;
    done = 1'b0;
    t0 = 0;
    rd = 'x;
    er = 1'bx;
    lat = -1;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; strb = s; wdata = d;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (gnt) begin
        got = 1'b1;
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("gnt_seen", 32'(got), 32'd1);
    @(negedge clk);
    req = 1'b0;
    if (got) begin
      for (int n = 0; n < 60; n++) begin
        if (rvalid) begin
          done = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rvalid_seen", 32'(done), 32'd1);
      if (done) begin
        rd = rdata;
        er = err;
        lat = cyc - t0;
      end
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          gcyc [10];
  int          gi;
  logic [5:0]  s_aw, s_w, s_b, s_rv;
  bit          seen;
  logic        rv_any;

  initial begin
    tbl[0] = '{1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h04, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h08, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 32'h08, 4'h3, 32'hAAAA5555, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 32'h08, 4'h0, 32'h0,        32'hFFFF5555, 1'b0};
    tbl[5] = '{1'b0, 32'h100, 4'h0, 32'h0,       ERR_EN ? 32'h0 : GARBAGE, ERR_EN};
    tbl[6] = '{1'b1, 32'h100, 4'hF, 32'h12345678, 32'h0, ERR_EN};
    tbl[7] = '{1'b0, 32'h3C, 4'h0, 32'h0,        32'h0, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; strb = '0; wdata = '0;

    // Reset state, with req held to show gnt stays low in reset
    repeat (2) @(negedge clk);
    req = 1'b1;
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_axi", 32'({ax.aw_valid, ax.w_valid, ax.b_ready, ax.ar_valid, ax.r_ready}), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;

    // Vector table with a zero-wait slave
    exp_lat_next = 3;
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, rd, er, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
    end

    // W channel stalled 3 cycles, AW immediate
    w_stall = 3;
    exp_lat_next = 6;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; strb = 4'hF; wdata = 32'hCAFEF00D;
    #1;
    chk("stall_gnt", 32'(gnt), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req = 1'b0;
      s_aw[k] = ax.aw_valid;
      s_w[k]  = ax.w_valid;
      s_b[k]  = ax.b_ready;
      s_rv[k] = rvalid;
    end
    chk("stall_aw_valid", 32'(s_aw), 32'b000001);
    chk("stall_w_valid", 32'(s_w), 32'b001111);
    chk("stall_b_ready", 32'(s_b), 32'b010000);
    chk("stall_rvalid", 32'(s_rv), 32'b100000);
    w_stall = 0;
    exp_lat_next = 3;
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    chk("stall_readback", rd, 32'hCAFEF00D);

    // Back-to-back reads with req held high
    for (int i = 0; i < 10; i++) do_txn(1'b1, 32'(4 * i), 4'hF, 32'(i), rd, er, lat);
    gi = 0;
    req = 1'b1; we = 1'b0;
    for (int c = 0; c < 100 && gi < 10; c++) begin
      @(negedge clk);
      addr = 32'(4 * gi);
      #1;
      if (gnt) begin
        gcyc[gi] = cyc;
        gi++;
      end
    end
    @(negedge clk);
    req = 1'b0;
    chk("b2b_grants", 32'(gi), 32'd10);
    for (int i = 1; i < 10; i++) chk($sformatf("b2b_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    repeat (5) @(negedge clk);
    chk("b2b_drain", 32'(sbq.size()), 32'd0);

    // Randomized traffic with random slave stalls
    exp_lat_next = -1;
    for (int i = 0; i < 40; i++) begin
      aw_stall = $urandom_range(0, 2);
      w_stall  = $urandom_range(0, 2);
      b_stall  = $urandom_range(0, 2);
      ar_stall = $urandom_range(0, 2);
      r_stall  = $urandom_range(0, 2);
      do_txn(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 19)),
             4'($urandom_range(0, 15)), $urandom, rd, er, lat);
    end
    aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;
    repeat (2) @(negedge clk);
    chk("rand_drain", 32'(sbq.size()), 32'd0);

    // Reset during WRESP with B withheld
    b_stall = 1000;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; strb = 4'hF; wdata = 32'h11112222;
    #1;
    chk("rst_seq_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (ax.b_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_seq_wresp", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    #1;
    chk("rst_seq_axi", 32'({ax.aw_valid, ax.w_valid, ax.b_ready, ax.ar_valid, ax.r_ready}), 32'd0);
    chk("rst_seq_gnt_low", 32'(gnt), 32'd0);
    chk("rst_seq_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    b_stall = 0;
    rv_any = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      rv_any = rv_any | rvalid;
    end
    chk("rst_seq_no_rvalid", 32'(rv_any), 32'd0);
    exp_lat_next = 3;
    do_txn(1'b1, 32'h20, 4'hF, 32'h33334444, rd, er, lat);
    chk("post_rst_write_err", 32'(er), 32'd0);
    chk("post_rst_write_lat", 32'(lat), 32'd3);
    do_txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    chk("post_rst_readback", rd, 32'h33334444);

    repeat (3) @(negedge clk);
    chk("final_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_to_axil.md
# mem_to_axil

Initiator-side bridge: turns a simple single-port memory request interface (req/we/addr/strb/wdata) into AXI-Lite master transactions. It is the counterpart of `axil_to_mem`, letting cores, DMA engines or test sequencers that speak the memory protocol drive an `axi_lite_xbar` slave port. One transaction in flight at a time. A result is returned on a one-cycle `rvalid` pulse with data and an error flag.

## Interface
- `ADDR_WIDTH`, default 32: address width on both interfaces.
- `DATA_WIDTH`, default 32: data width; `STRB_WIDTH = DATA_WIDTH/8` is derived.
- `PROT`, default 3'b000: constant driven on `aw_prot` and `ar_prot`.
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 1: memory request valid.
- `we`, in, 1: 1 = write, 0 = read.
- `addr`, in, ADDR_WIDTH: byte address.
- `strb`, in, STRB_WIDTH: write byte enables.
- `wdata`, in, DATA_WIDTH: write data.
- `gnt`, out, 1: request accepted this cycle; fields are captured.
- `rvalid`, out, 1: one-cycle completion pulse; issued for both reads and writes.
- `rdata`, out, DATA_WIDTH: read data, valid with `rvalid`; 0 for writes.
- `err`, out, 1: response error, valid with `rvalid`.
- `master`, AXI_LITE.Master modport, ADDR_WIDTH/DATA_WIDTH: AXI-Lite initiator port.

## Operation
- FSM states:
  - IDLE
  - WRITE: AW and W phases outstanding.
  - WRESP: B phase.
  - READ: AR phase.
  - RRESP: R phase.
- `gnt = req && state==IDLE && !rst`. This is combinational.
- On `gnt`:
  - Capture `addr`, `strb`, `wdata` and `we`.
  - Go to WRITE if `we`, otherwise READ.
- WRITE:
  - `aw_valid` and `w_valid` both assert in the first WRITE cycle.
  - Each valid drops independently after its own handshake; two "done" flags track this.
  - A simultaneous AW and W handshake completes both phases at once.
  - Go to WRESP when both are done.
- WRESP:
  - Hold `b_ready=1`.
  - On the B handshake, register `rvalid=1` and `err=b_resp[1]`, then return to IDLE.
- READ: hold `ar_valid` until `ar_ready`, then go to RRESP.
- RRESP:
  - Hold `r_ready=1`.
  - On the R handshake, register `rvalid=1`, `rdata=r_data` and `err=r_resp[1]`, then return to IDLE.
- AXI valids, once asserted, stay stable with stable payload until their handshake.
- `b_ready` and `r_ready` are 0 outside their response states.
- Responses arriving outside WRESP/RRESP are ignored; `ready` is 0 in those states.
- `rdata` holds its last value between pulses. A write completion drives `rdata=0`.

## Timing
- Reset values: every AXI valid/ready output 0, `gnt` 0, `rvalid` 0, `rdata` 0, `err` 0, state IDLE, done flags cleared.
- Latency with a zero-wait slave, taking the `gnt` cycle as T0:
  - T1: AW/W or AR handshake.
  - T2: B/R handshake.
  - T3: `rvalid`.
- The state is IDLE in the `rvalid` cycle, so a new `gnt` may coincide with `rvalid`. Peak throughput is one transaction every 3 cycles.
- `req` deasserting after `gnt` has no effect; the transaction completes.
- `rst` mid-transaction:
  - All AXI valids drop next edge.
  - No `rvalid` is issued for the aborted transaction.
  - The AXI slave is expected to be reset in the same domain.

## Configuration
- `MEM_TO_AXIL_ERR_EN` defined:
  - `err` reflects `resp[1]` (SLVERR/DECERR).
  - On a read error, `rdata` is forced to 0.
- Not defined:
  - `err` is tied 0.
  - `rdata` always forwards `r_data`.
  - Response codes are ignored.

## Test plan
- Write 0xDEADBEEF to 0x0004, strb 4'b1111, zero-wait `axil_to_mem`+ram -> `gnt` at T0, AW and W handshake at T1, `rvalid` at T3 with `err`=0. A subsequent read of 0x0004 returns 0xDEADBEEF.
- Slave stalls `w_ready` 3 cycles while `aw_ready` is immediate -> `aw_valid` drops at T2, `w_valid` holds to T4. `b_ready` only after both are done. `rvalid` arrives 3 cycles late; payload stable throughout.
- Back-to-back: `req` held for 10 reads of 0x0..0x9 after writing data=i -> one `gnt` per 3 cycles, `rdata`=i in order, never two transactions outstanding.
- Read to an unmapped address (xbar DECERR, r_resp=2'b11) -> with `MEM_TO_AXIL_ERR_EN`: `rvalid` with `err`=1, `rdata`=0. Without it: `err`=0.
- Partial write strb 4'b0011 of 0xAAAA5555 over 0xFFFFFFFF -> readback 0xFFFF5555.
- Assert `rst` while in WRESP with `b_valid` withheld -> next cycle all valids/readies 0, no `rvalid`. A fresh write after reset completes normally.
